keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

Parametrised row-scanning matrix keypad controller with input synchronisation, per-key debounce, multi-key rejection and press/release event pulses. It drives one-hot rows, samples the column lines, and reports a registered key index that holds until the next valid press. It sits between the board keypad pins and display/control logic and runs on the divided scan clock from the clock divider.

## Interface
Parameters:
- `ROWS`, 4: number of driven rows, ≥2.
- `COLS`, 4: number of sensed columns, ≥2.
- `SETTLE_CYC`, 3: cycles from a row change to column sampling, ≥2, which covers the synchronizer.
- `DEBOUNCE_CNT`, 4: consecutive stable samples required for press and for release, ≥1.
- Derived: `CODE_W = clog2(ROWS*COLS)`; `CNT_W = clog2(max(SETTLE_CYC, DEBOUNCE_CNT)+1)`.

Ports:
- `clk` in 1: scan clock, single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `scan_en` in 1: when low, scanning is frozen in SCAN state.
- `col` in COLS: raw column lines, active-high, asynchronous.
- `row` out ROWS: one-hot row drive, active-high.
- `key_code` out CODE_W: last accepted key, `row_idx*COLS + col_idx`; holds between presses.
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_held` out 1: high from acceptance until release is accepted.
- `key_release` out 1: one-cycle pulse when release is accepted.
- `multi_key` out 1: one-cycle pulse when a scan sample sees more than one column active.

## Operation
- `col` passes through a 2-flop synchronizer, giving `col_s`. All decisions use `col_s`.
- State register values: SCAN, DEBOUNCE, PRESSED. Internal registers: `row_idx`, `settle_cnt`, `db_cnt`, `cand_col`.
- **SCAN**:
  - `row = 1<<row_idx`. `settle_cnt` increments while `scan_en` is high and freezes while it is low.
  - On the sample cycle (`settle_cnt == SETTLE_CYC`):
    - `col_s == 0`: `row_idx` advances, wrapping `ROWS-1 → 0`; `settle_cnt` resets to 0.
    - `col_s` one-hot: latch `cand_col`, clear `db_cnt`, go to DEBOUNCE. `row_idx` is held.
    - `col_s` multi-hot: pulse `multi_key`, advance the row as for `col_s == 0`. No press is reported.
- **DEBOUNCE**:
  - Each cycle, `col_s == cand_col` increments `db_cnt`.
  - When `db_cnt` reaches `DEBOUNCE_CNT`: load `key_code`, pulse `key_valid`, set `key_held`, clear `db_cnt`, go to PRESSED.
  - Any mismatch: return to SCAN on the same row with `settle_cnt = 0`. No outputs change.
  - `scan_en` is ignored in this state.
- **PRESSED**:
  - `row` is held. `col_s == 0` increments `db_cnt`; any nonzero `col_s` (bounce, or other keys in the row) clears it.
  - When `db_cnt` reaches `DEBOUNCE_CNT`: pulse `key_release`, clear `key_held`, advance `row_idx` with wrap, set `settle_cnt = 0`, go to SCAN.
  - `key_code` keeps its value.
- Only one key is tracked at a time. Presses on other rows are not seen until release.
- `key_valid`, `key_release` and `multi_key` are mutually exclusive within a cycle.

## Timing
- Reset values:
  - `row = 1` (row 0), `row_idx = 0`, state SCAN, all counters 0, synchronizer flops 0.
  - `key_code = 0`, `key_valid = key_held = key_release = multi_key = 0`.
- Reset mid-press returns to SCAN on row 0 with no `key_release` pulse.
- All outputs are registered.
- Pin-to-`col_s` latency: 2 cycles.
- Row period with no key pressed: `SETTLE_CYC+1` cycles.
- `key_valid` asserts exactly `DEBOUNCE_CNT` cycles after the SCAN sample cycle that detected the key, provided the key is stable.
- `key_held` rises in the same cycle as `key_valid` and falls in the same cycle as `key_release`.
- `key_release` asserts `DEBOUNCE_CNT` cycles after the first cycle of an unbroken run of `col_s == 0`.
- On the cycle `scan_en` deasserts, an in-progress sample decision still completes. Freezing applies from the next cycle.

## Structure
- `keypad_pkg` holds the state encodings (`S_SCAN`, `S_DEBOUNCE`, `S_PRESSED`) and a constant `clog2` function. These are shared with future keypad and display blocks.
- One sub-module, `keypad_col_sync`: a COLS-wide 2-flop synchronizer with synchronous reset.
- The hex legend mapping (index → keycap label) is not part of this block. It lives in a downstream lookup.

## Test plan
All scenarios use ROWS=4, COLS=4, SETTLE_CYC=3, DEBOUNCE_CNT=4.
- **Idle scan:** no keys, `scan_en = 1` → `row` cycles 1,2,4,8,1 with 4 cycles per row. No pulses. `key_code` stays 0 after reset.
- **Clean press:** row 2 / col 1 held → `key_code = 9`, `key_valid` for 1 cycle 4 cycles after the sample, `key_held = 1`. Release → `key_release` 4 cycles after `col_s = 0`, then `row = 8`.
- **Bounce:** row 0 / col 3 toggling every 2 cycles for 10 cycles, then stable → exactly one `key_valid`, with `key_code = 3`. Release bounce gives exactly one `key_release`.
- **Ghost:** cols 0 and 2 both high on row 1 → `multi_key` pulses, no `key_valid`, and the scan advances to `row = 4`.
- **Freeze / wrap:** `scan_en = 0` on row 3 → `row` stays 8. Re-enable → wraps to `row = 1`. A press on row 3 / col 0 gives `key_code = 12`.
- **Reset:** assert `rst` for 1 cycle while PRESSED → the next cycle shows `row = 1`, `key_held = 0`, `key_code = 0`, and no `key_release`.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scanner state encodings and a constant log2 helper
// for sizing ports and counters.
package keypad_pkg;

   typedef enum logic [1:0] {
      S_SCAN     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_PRESSED  = 2'd2
   } kp_state_e;

   // Smallest r with 2**r >= n; usable in parameter expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
module keypad_col_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanning matrix keypad controller: one-hot row drive, column debounce,
// ghost (multi-column) rejection and registered press/release events.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int  ROWS         = 4,
   parameter int  COLS         = 4,
   parameter int  SETTLE_CYC   = 3,
   parameter int  DEBOUNCE_CNT = 4,
   localparam int CODE_W       = clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_en,
   input  logic [COLS-1:0]   col,
   output logic [ROWS-1:0]   row,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              key_release,
   output logic              multi_key
);

   localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CNT) ? SETTLE_CYC : DEBOUNCE_CNT;
   localparam int CNT_W   = clog2(CNT_MAX + 1);
   localparam int ROW_W   = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(DEBOUNCE_CNT - 1);
   // The SCAN sample that found the key is the first stable sample, so the
   // debounce state only needs DEBOUNCE_CNT-1 further matches.
   localparam logic [CNT_W-1:0] PRESS_LAST  = CNT_W'((DEBOUNCE_CNT >= 2) ? DEBOUNCE_CNT - 2 : 0);
   localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);

   logic [COLS-1:0]   col_s;

   kp_state_e         state_q, state_d;
   logic [ROW_W-1:0]  row_idx_q, row_idx_d;
   logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
   logic [COLS-1:0]   cand_col_q, cand_col_d;
   logic [ROWS-1:0]   row_q, row_d;
   logic [CODE_W-1:0] key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_held_q, key_held_d;
   logic              key_release_q, key_release_d;
   logic              multi_key_q, multi_key_d;

   logic              col_any, col_onehot, accept;
   logic [ROW_W-1:0]  next_row;
   logic [COLS-1:0]   accept_col;
   logic [CODE_W-1:0] accept_idx, accept_code;

   keypad_col_sync #(.W(COLS)) u_col_sync (
      .clk (clk),
      .rst (rst),
      .d   (col),
      .q   (col_s)
   );

   always_comb begin
      col_any    = |col_s;
      col_onehot = col_any && ((col_s & (col_s - COLS'(1))) == '0);
      next_row   = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + ROW_W'(1);

      // With a single-sample debounce the press is accepted straight from SCAN.
      accept_col = (state_q == S_SCAN) ? col_s : cand_col_q;
      accept_idx = '0;
      for (int c = 0; c < COLS; c++) begin
         if (accept_col[c]) accept_idx = CODE_W'(c);
      end
      accept_code = CODE_W'(row_idx_q) * CODE_W'(COLS) + accept_idx;
   end

   always_comb begin
      state_d       = state_q;
      row_idx_d     = row_idx_q;
      settle_cnt_d  = settle_cnt_q;
      db_cnt_d      = db_cnt_q;
      cand_col_d    = cand_col_q;
      key_code_d    = key_code_q;
      key_held_d    = key_held_q;
      key_valid_d   = 1'b0;
      key_release_d = 1'b0;
      multi_key_d   = 1'b0;
      accept        = 1'b0;

      case (state_q)
         S_SCAN: begin
            // The sample decision is not gated by scan_en, so a freeze that
            // lands on the sample cycle still lets that decision complete.
            if (settle_cnt_q == SETTLE_LAST) begin
               settle_cnt_d = '0;
               if (col_onehot) begin
                  cand_col_d = col_s;
                  db_cnt_d   = '0;
                  if (DEBOUNCE_CNT == 1) accept = 1'b1;
                  else                   state_d = S_DEBOUNCE;
               end else begin
                  multi_key_d = col_any;
                  row_idx_d   = next_row;
               end
            end else if (scan_en) begin
               settle_cnt_d = settle_cnt_q + CNT_W'(1);
            end
         end

         S_DEBOUNCE: begin
            if (col_s == cand_col_q) begin
               if (db_cnt_q == PRESS_LAST) accept = 1'b1;
               else                        db_cnt_d = db_cnt_q + CNT_W'(1);
            end else begin
               state_d      = S_SCAN;
               settle_cnt_d = '0;
               db_cnt_d     = '0;
            end
         end

         S_PRESSED: begin
            // Any column activity on the held row restarts the release count.
            if (col_any) begin
               db_cnt_d = '0;
            end else if (db_cnt_q == REL_LAST) begin
               key_release_d = 1'b1;
               key_held_d    = 1'b0;
               db_cnt_d      = '0;
               row_idx_d     = next_row;
               settle_cnt_d  = '0;
               state_d       = S_SCAN;
            end else begin
               db_cnt_d = db_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d      = S_SCAN;
            settle_cnt_d = '0;
            db_cnt_d     = '0;
         end
      endcase

      if (accept) begin
         key_code_d  = accept_code;
         key_valid_d = 1'b1;
         key_held_d  = 1'b1;
         db_cnt_d    = '0;
         state_d     = S_PRESSED;
      end

      row_d = ROWS'(1) << row_idx_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_SCAN;
         row_idx_q     <= '0;
         settle_cnt_q  <= '0;
         db_cnt_q      <= '0;
         cand_col_q    <= '0;
         row_q         <= ROWS'(1);
         key_code_q    <= '0;
         key_valid_q   <= 1'b0;
         key_held_q    <= 1'b0;
         key_release_q <= 1'b0;
         multi_key_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_idx_q     <= row_idx_d;
         settle_cnt_q  <= settle_cnt_d;
         db_cnt_q      <= db_cnt_d;
         cand_col_q    <= cand_col_d;
         row_q         <= row_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_held_q    <= key_held_d;
         key_release_q <= key_release_d;
         multi_key_q   <= multi_key_d;
      end
   end

   assign row         = row_q;
   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_held    = key_held_q;
   assign key_release = key_release_q;
   assign multi_key   = multi_key_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: a keypad model closes columns on
// the driven row; table vectors plus hand sequences for timing corners.
module tb_keypad_matrix_scanner;

   localparam int ROWS = 4, COLS = 4, SETTLE_CYC = 3, DEBOUNCE_CNT = 4, CODE_W = 4;
   localparam int NV = 11;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 scan_en;
   logic [COLS-1:0]      col;
   logic [ROWS-1:0]      row;
   logic [CODE_W-1:0]    key_code;
   logic                 key_valid, key_held, key_release, multi_key;
   logic [ROWS*COLS-1:0] keys;

   int checks = 0, errors = 0;
   int n_valid, n_rel, n_multi;

   typedef struct {
      bit              rst;
      logic [15:0]     keys;
      bit              en;
      int              n;
      int              row;
      int              code;
      int              held;
      int              nv;
      int              nr;
      int              nm;
   } vec_t;

   vec_t tbl[NV];

   always #5 clk = ~clk;

   keypad_matrix_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(SETTLE_CYC), .DEBOUNCE_CNT(DEBOUNCE_CNT)
   ) dut (
      .clk(clk), .rst(rst), .scan_en(scan_en), .col(col), .row(row),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
      .key_release(key_release), .multi_key(multi_key)
   );

   // A pressed key shorts its row line onto its column line.
   always_comb begin
      col = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (row[r] && keys[r*COLS + c]) col[c] = 1'b1;
   end

   task automatic clr();
      n_valid = 0; n_rel = 0; n_multi = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      n_valid += int'(key_valid);
      n_rel   += int'(key_release);
      n_multi += int'(multi_key);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; keys = '0; scan_en = 1'b1;
      tick(); tick();
      rst = 1'b0;
      clr();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      //            rst keys     en  n  row code held nv nr nm
      tbl[0]  = '{1, 16'h0000, 1,  0, 1,  0,   0,   0, 0, 0};
      tbl[1]  = '{0, 16'h0000, 1,  4, 2,  0,   0,   0, 0, 0};
      tbl[2]  = '{0, 16'h0000, 1, 12, 1,  0,   0,   0, 0, 0};
      tbl[3]  = '{1, 16'h0000, 1,  0, 1,  0,   0,   0, 0, 0};
      tbl[4]  = '{0, 16'h0200, 1, 16, 4,  9,   1,   1, 0, 0};
      tbl[5]  = '{0, 16'h0000, 1,  8, 8,  9,   0,   0, 1, 0};
      tbl[6]  = '{1, 16'h0000, 1,  0, 1,  0,   0,   0, 0, 0};
      tbl[7]  = '{0, 16'h0050, 1, 10, 4,  0,   0,   0, 0, 1};
      tbl[8]  = '{0, 16'h0050, 1, 16, 4,  0,   0,   0, 0, 1};
      tbl[9]  = '{1, 16'h0000, 1,  0, 1,  0,   0,   0, 0, 0};
      tbl[10] = '{0, 16'h0080, 1, 14, 2,  7,   1,   1, 0, 0};

      rst = 1'b1; keys = '0; scan_en = 1'b1;

      for (int i = 0; i < NV; i++) begin
         if (tbl[i].rst) begin
            do_reset();
         end else begin
            keys = tbl[i].keys; scan_en = tbl[i].en;
            clr();
            repeat (tbl[i].n) tick();
         end
         chk($sformatf("v%0d.row", i),  int'(row), tbl[i].row);
         chk($sformatf("v%0d.code", i), int'(key_code), tbl[i].code);
         chk($sformatf("v%0d.held", i), int'(key_held), tbl[i].held);
         chk($sformatf("v%0d.valid", i),   tbl[i].rst ? int'(key_valid)   : n_valid, tbl[i].nv);
         chk($sformatf("v%0d.release", i), tbl[i].rst ? int'(key_release) : n_rel,   tbl[i].nr);
         chk($sformatf("v%0d.multi", i),   tbl[i].rst ? int'(multi_key)   : n_multi, tbl[i].nm);
      end

      // Idle scan: four cycles per row, wrapping through all rows.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         chk($sformatf("idle.row%0d", k), int'(row), 1 << ((k / 4) % 4));
         tick();
      end
      chk("idle.pulses", n_valid + n_rel + n_multi, 0);
      chk("idle.code", int'(key_code), 0);

      // Clean press timing: sample at cycle 11, valid at 15; release at 20, col_s low at 22.
      do_reset();
      keys = 16'h0200;
      repeat (14) tick();
      chk("press.early_valid", int'(key_valid), 0);
      tick();
      chk("press.valid", int'(key_valid), 1);
      chk("press.held", int'(key_held), 1);
      chk("press.code", int'(key_code), 9);
      tick();
      chk("press.valid_pulse", int'(key_valid), 0);
      repeat (4) tick();
      keys = '0;
      repeat (5) tick();
      chk("rel.early", int'(key_release), 0);
      chk("rel.held_before", int'(key_held), 1);
      chk("rel.row_before", int'(row), 4);
      tick();
      chk("rel.pulse", int'(key_release), 1);
      chk("rel.held_after", int'(key_held), 0);
      chk("rel.row_after", int'(row), 8);
      tick();
      chk("rel.pulse_end", int'(key_release), 0);

      // Bounce on row 0 / col 3, then stable; release also bounces.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         keys = ((i / 2) % 2 == 0) ? 16'h0008 : 16'h0000;
         tick();
      end
      keys = 16'h0008;
      repeat (30) tick();
      chk("bounce.nvalid", n_valid, 1);
      chk("bounce.code", int'(key_code), 3);
      chk("bounce.held", int'(key_held), 1);
      clr();
      for (int i = 0; i < 10; i++) begin
         keys = ((i / 2) % 2 == 0) ? 16'h0000 : 16'h0008;
         tick();
      end
      keys = '0;
      repeat (20) tick();
      chk("bounce.nrelease", n_rel, 1);
      chk("bounce.nvalid_rel", n_valid, 0);
      chk("bounce.held_rel", int'(key_held), 0);

      // scan_en dropping on the sample cycle: the row advance still happens.
      do_reset();
      repeat (3) tick();
      scan_en = 1'b0;
      tick();
      chk("frz.sample_done", int'(row), 2);
      repeat (5) tick();
      chk("frz.hold", int'(row), 2);
      scan_en = 1'b1;
      repeat (3) tick();
      chk("frz.resume_early", int'(row), 2);
      tick();
      chk("frz.resume", int'(row), 4);

      // Freeze on row 3, wrap to row 0, then press row 3 / col 0.
      do_reset();
      repeat (13) tick();
      chk("wrap.row3", int'(row), 8);
      scan_en = 1'b0;
      repeat (10) tick();
      chk("wrap.frozen", int'(row), 8);
      scan_en = 1'b1;
      repeat (2) tick();
      chk("wrap.pre", int'(row), 8);
      tick();
      chk("wrap.row0", int'(row), 1);
      keys = 16'h1000;
      clr();
      repeat (20) tick();
      chk("wrap.nvalid", n_valid, 1);
      chk("wrap.code", int'(key_code), 12);
      chk("wrap.row_held", int'(row), 8);
      chk("wrap.held", int'(key_held), 1);

      // One-cycle reset while PRESSED.
      rst = 1'b1;
      clr();
      tick();
      chk("rstp.row", int'(row), 1);
      chk("rstp.held", int'(key_held), 0);
      chk("rstp.code", int'(key_code), 0);
      chk("rstp.release", int'(key_release), 0);
      rst = 1'b0; keys = '0;
      tick();
      chk("rstp.no_release", n_rel, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
